// File: rtl/lsu_pkg.sv
// Shared types and widths for the load/store unit: access-size encodings,
// FSM states and the lane widths used by the align datapath.
package lsu_pkg;

  localparam int XLEN   = 32;
  localparam int BYTE_W = 8;
  localparam int HALF_W = 16;
  localparam int LANES  = XLEN / BYTE_W;

  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10,
    SZ_X = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RD   = 2'b01,
    ST_WR   = 2'b10,
    ST_RESP = 2'b11
  } state_e;

endpackage

// File: rtl/lsu_if.sv
// Core request/response handshake plus the word-addressed data memory port.
// master = core + memory side, slave = the LSU.
interface lsu_if;

  logic        lsu_req_valid;
  logic        lsu_req_ready;
  logic        lsu_req_store;
  logic [1:0]  lsu_req_size;
  logic        lsu_req_unsigned;
  logic [31:0] lsu_req_addr;
  logic [31:0] lsu_req_wdata;
  logic        lsu_resp_valid;
  logic        lsu_resp_ready;
  logic [31:0] lsu_resp_rdata;
  logic        lsu_resp_err;
  logic        lsu_mem_MemRead;
  logic        lsu_mem_MemWrite;
  logic [31:0] lsu_mem_address;
  logic [31:0] lsu_mem_Write;
  logic [31:0] lsu_mem_Read;

  modport master (
    output lsu_req_valid, lsu_req_store, lsu_req_size, lsu_req_unsigned,
           lsu_req_addr, lsu_req_wdata, lsu_resp_ready, lsu_mem_Read,
    input  lsu_req_ready, lsu_resp_valid, lsu_resp_rdata, lsu_resp_err,
           lsu_mem_MemRead, lsu_mem_MemWrite, lsu_mem_address, lsu_mem_Write
  );

  modport slave (
    input  lsu_req_valid, lsu_req_store, lsu_req_size, lsu_req_unsigned,
           lsu_req_addr, lsu_req_wdata, lsu_resp_ready, lsu_mem_Read,
    output lsu_req_ready, lsu_resp_valid, lsu_resp_rdata, lsu_resp_err,
           lsu_mem_MemRead, lsu_mem_MemWrite, lsu_mem_address, lsu_mem_Write
  );

endinterface

// File: rtl/lsu_align.sv
// Combinational lane handling: sub-word load extraction with sign/zero
// extension, and merging right-aligned store data into a fetched word.
module lsu_align
  import lsu_pkg::*;
(
  input  size_e             size,
  input  logic              is_unsigned,
  input  logic [1:0]        byte_off,
  input  logic [XLEN-1:0]   rword,
  input  logic [XLEN-1:0]   wdata,
  output logic [XLEN-1:0]   load_data,
  output logic [XLEN-1:0]   merged
);

  logic [1:0]      lane_off;
  logic [XLEN-1:0] shifted;

  // Halfwords are selected by addr[1] alone, so the low offset bit is dropped.
  assign lane_off = (size == SZ_H) ? {byte_off[1], 1'b0} : byte_off;
  assign shifted  = rword >> {lane_off, 3'b000};

  always_comb begin
    load_data = rword;
    case (size)
      SZ_B:    load_data = {{(XLEN-BYTE_W){~is_unsigned & shifted[BYTE_W-1]}},
                            shifted[BYTE_W-1:0]};
      SZ_H:    load_data = {{(XLEN-HALF_W){~is_unsigned & shifted[HALF_W-1]}},
                            shifted[HALF_W-1:0]};
      default: load_data = rword;
    endcase
  end

  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      localparam logic [1:0] LANE = gi;
      logic              lane_en;
      logic [BYTE_W-1:0] lane_src;

      assign lane_en = (size == SZ_W) ||
                       (size == SZ_H && byte_off[1] == LANE[1]) ||
                       (size == SZ_B && byte_off == LANE);

      always_comb begin
        case (size)
          SZ_B:    lane_src = wdata[BYTE_W-1:0];
          SZ_H:    lane_src = wdata[BYTE_W*(gi%2) +: BYTE_W];
          default: lane_src = wdata[BYTE_W*gi +: BYTE_W];
        endcase
      end

      assign merged[BYTE_W*gi +: BYTE_W] = lane_en ? lane_src
                                                   : rword[BYTE_W*gi +: BYTE_W];
    end
  endgenerate

endmodule

// File: rtl/lsu.sv
// Load/store unit FSM: IDLE -> (RD) -> (WR) -> RESP, byte/half access over a
// word memory. Define LSU_MISALIGN_CHECK_EN to flag misaligned half/word accesses.
module lsu
  import lsu_pkg::*;
(
  input  logic lsu_clk,
  input  logic lsu_rst_n,
  lsu_if.slave bus
);

  state_e          state_reg;
  logic            store_reg;
  logic            unsigned_reg;
  size_e           size_reg;
  logic [1:0]      off_reg;
  logic [XLEN-1:0] wdata_reg;
  logic            mem_read_reg;
  logic            mem_write_reg;
  logic [XLEN-1:0] mem_addr_reg;
  logic [XLEN-1:0] mem_wdata_reg;
  logic            resp_valid_reg;
  logic            resp_err_reg;
  logic [XLEN-1:0] resp_rdata_reg;

  size_e           req_size;
  logic            req_err;
  logic [XLEN-1:0] load_data;
  logic [XLEN-1:0] merged_word;

  assign req_size = size_e'(bus.lsu_req_size);

  always_comb begin
    req_err = (req_size == SZ_X);
`ifdef LSU_MISALIGN_CHECK_EN
    if (req_size == SZ_H && bus.lsu_req_addr[0])
      req_err = 1'b1;
    if (req_size == SZ_W && bus.lsu_req_addr[1:0] != 2'b00)
      req_err = 1'b1;
`endif
  end

  lsu_align u_align (
    .size        (size_reg),
    .is_unsigned (unsigned_reg),
    .byte_off    (off_reg),
    .rword       (bus.lsu_mem_Read),
    .wdata       (wdata_reg),
    .load_data   (load_data),
    .merged      (merged_word)
  );

  always_ff @(posedge lsu_clk or negedge lsu_rst_n) begin
    if (!lsu_rst_n) begin
      state_reg      <= ST_IDLE;
      store_reg      <= 1'b0;
      unsigned_reg   <= 1'b0;
      size_reg       <= SZ_B;
      off_reg        <= 2'b00;
      wdata_reg      <= '0;
      mem_read_reg   <= 1'b0;
      mem_write_reg  <= 1'b0;
      mem_addr_reg   <= '0;
      mem_wdata_reg  <= '0;
      resp_valid_reg <= 1'b0;
      resp_err_reg   <= 1'b0;
      resp_rdata_reg <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: if (bus.lsu_req_valid) begin
          store_reg    <= bus.lsu_req_store;
          size_reg     <= req_size;
          unsigned_reg <= bus.lsu_req_unsigned;
          off_reg      <= bus.lsu_req_addr[1:0];
          wdata_reg    <= bus.lsu_req_wdata;
          if (req_err) begin
            state_reg      <= ST_RESP;
            resp_valid_reg <= 1'b1;
            resp_err_reg   <= 1'b1;
          end else begin
            mem_addr_reg <= {bus.lsu_req_addr[XLEN-1:2], 2'b00};
            // Full-word stores need no read-modify-write.
            if (bus.lsu_req_store && req_size == SZ_W) begin
              state_reg     <= ST_WR;
              mem_write_reg <= 1'b1;
              mem_wdata_reg <= bus.lsu_req_wdata;
            end else begin
              state_reg    <= ST_RD;
              mem_read_reg <= 1'b1;
            end
          end
        end
        ST_RD: begin
          mem_read_reg <= 1'b0;
          if (store_reg) begin
            state_reg     <= ST_WR;
            mem_write_reg <= 1'b1;
            mem_wdata_reg <= merged_word;
          end else begin
            state_reg      <= ST_RESP;
            mem_addr_reg   <= '0;
            resp_valid_reg <= 1'b1;
            resp_rdata_reg <= load_data;
          end
        end
        ST_WR: begin
          state_reg      <= ST_RESP;
          mem_write_reg  <= 1'b0;
          mem_addr_reg   <= '0;
          mem_wdata_reg  <= '0;
          resp_valid_reg <= 1'b1;
        end
        ST_RESP: if (bus.lsu_resp_ready) begin
          state_reg      <= ST_IDLE;
          resp_valid_reg <= 1'b0;
          resp_err_reg   <= 1'b0;
          resp_rdata_reg <= '0;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign bus.lsu_req_ready    = (state_reg == ST_IDLE);
  assign bus.lsu_resp_valid   = resp_valid_reg;
  assign bus.lsu_resp_err     = resp_err_reg;
  assign bus.lsu_resp_rdata   = resp_rdata_reg;
  assign bus.lsu_mem_MemRead  = mem_read_reg;
  assign bus.lsu_mem_MemWrite = mem_write_reg;
  assign bus.lsu_mem_address  = mem_addr_reg;
  assign bus.lsu_mem_Write    = mem_wdata_reg;

endmodule
